// File: rtl/lockin_demod_accum_pkg.sv
// Shared constants for the lock-in chain: accumulator sizing, config width and
// the {hi,lo} lane packing used on the reference and result buses.
package lockin_pkg;

    localparam int DEC_W   = 5;
    localparam int LANE_LO = 0;   // cos on the reference bus, X on the result bus
    localparam int LANE_HI = 1;   // sin on the reference bus, Y on the result bus

    function automatic int acc_width(input int data_w, input int ref_w, input int max_dec);
        return data_w + ref_w + max_dec;
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/lockin_demod_accum_if.sv
// Valid-only streams around the demodulator: signal/reference in, {Y,X} out.
interface lockin_demod_accum_if #(
    parameter int DATA_WIDTH = 16,
    parameter int REF_WIDTH  = 16,
    parameter int OUT_WIDTH  = 32
);
    logic [DATA_WIDTH-1:0]  S_AXIS_tdata;
    logic                   S_AXIS_tvalid;
    logic [2*REF_WIDTH-1:0] S_AXIS_REF_tdata;
    logic                   S_AXIS_REF_tvalid;
    logic [2*OUT_WIDTH-1:0] M_AXIS_tdata;
    logic                   M_AXIS_tvalid;

    modport master (
        output S_AXIS_tdata, S_AXIS_tvalid, S_AXIS_REF_tdata, S_AXIS_REF_tvalid,
        input  M_AXIS_tdata, M_AXIS_tvalid
    );

    modport slave (
        input  S_AXIS_tdata, S_AXIS_tvalid, S_AXIS_REF_tdata, S_AXIS_REF_tvalid,
        output M_AXIS_tdata, M_AXIS_tvalid
    );
endinterface

// File: rtl/lockin_demod_accum_mac.sv
// One mixing channel: registered product, period accumulator, closed-period sum,
// then arithmetic shift and saturation into the held output register.
module lockin_mac
    import lockin_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 16,
    parameter int AW = 48,
    parameter int OW = 32
)(
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 i_restart,
    input  logic signed [DW-1:0] i_sample,
    input  logic signed [RW-1:0] i_ref,
    input  logic                 i_acc_en,
    input  logic                 i_acc_last,
    input  logic                 i_out_en,
    input  logic [DEC_W-1:0]     i_shift,
    output logic signed [OW-1:0] o_result
);
    localparam int PW = DW + RW;
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic signed [PW-1:0] r_prod;
    logic signed [AW-1:0] r_acc;
    logic signed [AW-1:0] r_sum;
    logic signed [OW-1:0] r_res;
    logic signed [AW-1:0] w_acc_sum;
    logic signed [AW-1:0] w_shifted;
    logic signed [OW-1:0] w_sat;

    assign w_acc_sum = r_acc + {{(AW-PW){r_prod[PW-1]}}, r_prod};
    assign w_shifted = r_sum >>> i_shift;

    always_comb begin
        w_sat = w_shifted[OW-1:0];
        if (w_shifted > SAT_MAX) begin
            w_sat = SAT_MAX[OW-1:0];
        end else if (w_shifted < SAT_MIN) begin
            w_sat = SAT_MIN[OW-1:0];
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_prod <= '0;
            r_acc  <= '0;
            r_sum  <= '0;
            r_res  <= '0;
        end else begin
            r_prod <= PW'(i_sample) * PW'(i_ref);
            // The closing product lands in r_sum while r_acc restarts empty,
            // so the next period's first product is never lost.
            if (i_restart) begin
                r_acc <= '0;
            end else if (i_acc_en) begin
                if (i_acc_last) begin
                    r_sum <= w_acc_sum;
                    r_acc <= '0;
                end else begin
                    r_acc <= w_acc_sum;
                end
            end
            if (i_out_en) begin
                r_res <= w_sat;
            end
        end
    end

    assign o_result = r_res;
endmodule

// File: rtl/lockin_demod_accum.sv
// Lock-in demodulate-and-average: acceptance, period counting, decimation latch,
// restart handling and the valid pipeline around two lockin_mac channels.
module lockin_demod_accum
    import lockin_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int REF_WIDTH    = 16,
    parameter int MAX_DEC_LOG2 = 16,
    parameter int OUT_WIDTH    = 32
)(
    input  logic                 aclk,
    input  logic                 aresetn,
    lockin_demod_accum_if.slave  axis,
    input  logic [DEC_W-1:0]     cfg_dec_log2,
    input  logic                 cfg_restart,
    output logic [15:0]          sts_mismatch
);
    localparam int AW = acc_width(DATA_WIDTH, REF_WIDTH, MAX_DEC_LOG2);
    localparam int CW = (MAX_DEC_LOG2 > 0) ? MAX_DEC_LOG2 : 1;

    logic [CW-1:0]            r_cnt;
    logic [DEC_W-1:0]         r_dec;
    logic                     r_p1_valid, r_p1_last;
    logic [DEC_W-1:0]         r_p1_dec;
    logic [DATA_WIDTH-1:0]    r_p1_sample;
    logic [2*REF_WIDTH-1:0]   r_p1_ref;
    logic                     r_p2_valid, r_p2_last;
    logic [DEC_W-1:0]         r_p2_dec;
    logic                     r_sum_valid;
    logic [DEC_W-1:0]         r_sum_dec;
    logic                     r_out_valid;
    logic [15:0]              r_mismatch;

    logic                     w_accept;
    logic                     w_mismatch;
    logic [CW-1:0]            w_cnt_cur;
    logic [DEC_W-1:0]         w_cfg_clamped;
    logic [DEC_W-1:0]         w_dec_cur;
    logic [CW:0]              w_mask;
    logic                     w_last;
    logic [2*OUT_WIDTH-1:0]   w_result;

    assign w_accept   = axis.S_AXIS_tvalid & axis.S_AXIS_REF_tvalid;
    assign w_mismatch = axis.S_AXIS_tvalid ^ axis.S_AXIS_REF_tvalid;

    // A restart in the same cycle as an accepted sample makes it sample 1.
    assign w_cnt_cur     = cfg_restart ? '0 : r_cnt;
    assign w_cfg_clamped = (cfg_dec_log2 > DEC_W'(MAX_DEC_LOG2)) ? DEC_W'(MAX_DEC_LOG2) : cfg_dec_log2;
    assign w_dec_cur     = (w_cnt_cur == '0) ? w_cfg_clamped : r_dec;
    assign w_mask        = ((CW+1)'(1) << w_dec_cur) - (CW+1)'(1);
    assign w_last        = ({1'b0, w_cnt_cur} == w_mask);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_cnt       <= '0;
            r_dec       <= '0;
            r_p1_valid  <= 1'b0;
            r_p1_last   <= 1'b0;
            r_p1_dec    <= '0;
            r_p1_sample <= '0;
            r_p1_ref    <= '0;
            r_p2_valid  <= 1'b0;
            r_p2_last   <= 1'b0;
            r_p2_dec    <= '0;
            r_sum_valid <= 1'b0;
            r_sum_dec   <= '0;
            r_out_valid <= 1'b0;
            r_mismatch  <= '0;
        end else begin
            if (w_accept) begin
                r_cnt <= w_last ? '0 : w_cnt_cur + CW'(1);
                if (w_cnt_cur == '0) begin
                    r_dec <= w_dec_cur;
                end
            end else if (cfg_restart) begin
                r_cnt <= '0;
            end
            r_p1_valid  <= w_accept;
            r_p1_last   <= w_accept & w_last;
            r_p1_dec    <= w_dec_cur;
            r_p1_sample <= axis.S_AXIS_tdata;
            r_p1_ref    <= axis.S_AXIS_REF_tdata;
            r_p2_valid  <= r_p1_valid & ~cfg_restart;
            r_p2_last   <= r_p1_last & ~cfg_restart;
            r_p2_dec    <= r_p1_dec;
            r_sum_valid <= r_p2_valid & r_p2_last & ~cfg_restart;
            if (r_p2_valid && r_p2_last) begin
                r_sum_dec <= r_p2_dec;
            end
            r_out_valid <= r_sum_valid;
            if (w_mismatch && (r_mismatch != 16'hFFFF)) begin
                r_mismatch <= r_mismatch + 16'd1;
            end
        end
    end

    generate
        for (genvar gi = LANE_LO; gi <= LANE_HI; gi++) begin : g_lane
            lockin_mac #(
                .DW (DATA_WIDTH),
                .RW (REF_WIDTH),
                .AW (AW),
                .OW (OUT_WIDTH)
            ) u_mac (
                .aclk       (aclk),
                .aresetn    (aresetn),
                .i_restart  (cfg_restart),
                .i_sample   (r_p1_sample),
                .i_ref      (r_p1_ref[lane_lsb(gi, REF_WIDTH) +: REF_WIDTH]),
                .i_acc_en   (r_p2_valid),
                .i_acc_last (r_p2_last),
                .i_out_en   (r_sum_valid),
                .i_shift    (r_sum_dec),
                .o_result   (w_result[lane_lsb(gi, OUT_WIDTH) +: OUT_WIDTH])
            );
        end
    endgenerate

    assign axis.M_AXIS_tdata  = w_result;
    assign axis.M_AXIS_tvalid = r_out_valid;
    assign sts_mismatch       = r_mismatch;
endmodule

// File: tb/tb_lockin_demod_accum.sv
// Scoreboard bench: the driver pushes expected {edge,X,Y} per closed period,
// monitors on both DUT widths (32 and 24 bit outputs) pop and compare.
module tb_lockin_demod_accum;
    import lockin_pkg::*;

    typedef struct {
        int     e;
        longint x;
        longint y;
    } exp_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cfg_restart = 1'b0;
    logic [4:0]  cfg_dec = 5'd0;
    logic        s_valid = 1'b0;
    logic        r_valid = 1'b0;
    logic [15:0] s_data = 16'd0;
    logic [31:0] r_data = 32'd0;
    logic [15:0] mis32;
    logic [15:0] mis24;

    int     edge_cnt = 0;
    int     total = 0;
    int     passed = 0;
    exp_t   q32[$];
    exp_t   q24[$];
    int     m_cnt = 0;
    int     m_dec = 0;
    int     m_mis = 0;
    longint m_ax = 0;
    longint m_ay = 0;

    lockin_demod_accum_if #(.DATA_WIDTH(16), .REF_WIDTH(16), .OUT_WIDTH(32)) bus32();
    lockin_demod_accum_if #(.DATA_WIDTH(16), .REF_WIDTH(16), .OUT_WIDTH(24)) bus24();

    assign bus32.S_AXIS_tdata      = s_data;
    assign bus32.S_AXIS_tvalid     = s_valid;
    assign bus32.S_AXIS_REF_tdata  = r_data;
    assign bus32.S_AXIS_REF_tvalid = r_valid;
    assign bus24.S_AXIS_tdata      = s_data;
    assign bus24.S_AXIS_tvalid     = s_valid;
    assign bus24.S_AXIS_REF_tdata  = r_data;
    assign bus24.S_AXIS_REF_tvalid = r_valid;

    lockin_demod_accum #(.DATA_WIDTH(16), .REF_WIDTH(16), .MAX_DEC_LOG2(16), .OUT_WIDTH(32)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .axis         (bus32),
        .cfg_dec_log2 (cfg_dec),
        .cfg_restart  (cfg_restart),
        .sts_mismatch (mis32)
    );

    lockin_demod_accum #(.DATA_WIDTH(16), .REF_WIDTH(16), .MAX_DEC_LOG2(16), .OUT_WIDTH(24)) dut24 (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .axis         (bus24),
        .cfg_dec_log2 (cfg_dec),
        .cfg_restart  (cfg_restart),
        .sts_mismatch (mis24)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic longint sat(input longint v, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // One clock of stimulus plus the matching update of the behavioural model.
    task automatic cyc(input bit sv, input bit rv, input int smp, input int c, input int s, input bit rst);
        exp_t e;
        s_valid     = sv;
        r_valid     = rv;
        s_data      = 16'(smp);
        r_data      = {16'(s), 16'(c)};
        cfg_restart = rst;
        @(posedge aclk);
        #1;
        if (rst) begin
            m_cnt = 0;
            m_ax  = 0;
            m_ay  = 0;
        end
        if ((sv != rv) && (m_mis < 65535)) m_mis++;
        if (sv && rv) begin
            if (m_cnt == 0) m_dec = (int'(cfg_dec) > 16) ? 16 : int'(cfg_dec);
            m_ax += longint'(smp) * longint'(c);
            m_ay += longint'(smp) * longint'(s);
            m_cnt++;
            if (m_cnt == (1 << m_dec)) begin
                e.e = edge_cnt + 3;
                e.x = sat(m_ax >>> m_dec, 32);
                e.y = sat(m_ay >>> m_dec, 32);
                q32.push_back(e);
                e.x = sat(m_ax >>> m_dec, 24);
                e.y = sat(m_ay >>> m_dec, 24);
                q24.push_back(e);
                m_cnt = 0;
                m_ax  = 0;
                m_ay  = 0;
            end
        end
        s_valid     = 1'b0;
        r_valid     = 1'b0;
        cfg_restart = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_tvalid32"}, longint'(bus32.M_AXIS_tvalid), 0);
        check({tag, "_tdata32"}, longint'(bus32.M_AXIS_tdata), 0);
        check({tag, "_mis32"}, longint'(mis32), 0);
        check({tag, "_tvalid24"}, longint'(bus24.M_AXIS_tvalid), 0);
        check({tag, "_tdata24"}, longint'(bus24.M_AXIS_tdata[47:0]), 0);
        check({tag, "_mis24"}, longint'(mis24), 0);
    endtask

    always @(negedge aclk) begin : mon32
        exp_t e;
        if (bus32.M_AXIS_tvalid) begin
            $display("strobe32 edge=%0d X=%0d Y=%0d", edge_cnt,
                     $signed(bus32.M_AXIS_tdata[31:0]), $signed(bus32.M_AXIS_tdata[63:32]));
            if (q32.size() == 0) begin
                check("extra_strobe32", longint'(edge_cnt), -1);
            end else begin
                e = q32.pop_front();
                check("edge32", longint'(edge_cnt), longint'(e.e));
                check("x32", longint'($signed(bus32.M_AXIS_tdata[31:0])), e.x);
                check("y32", longint'($signed(bus32.M_AXIS_tdata[63:32])), e.y);
            end
        end
    end

    always @(negedge aclk) begin : mon24
        exp_t e;
        if (bus24.M_AXIS_tvalid) begin
            $display("strobe24 edge=%0d X=%0d Y=%0d", edge_cnt,
                     $signed(bus24.M_AXIS_tdata[23:0]), $signed(bus24.M_AXIS_tdata[47:24]));
            if (q24.size() == 0) begin
                check("extra_strobe24", longint'(edge_cnt), -1);
            end else begin
                e = q24.pop_front();
                check("edge24", longint'(edge_cnt), longint'(e.e));
                check("x24", longint'($signed(bus24.M_AXIS_tdata[23:0])), e.x);
                check("y24", longint'($signed(bus24.M_AXIS_tdata[47:24])), e.y);
            end
        end
    end

    initial begin
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check_zero_outputs("reset");
        aresetn = 1'b1;
        idle(2);

        // Test 1: X = 1000*16384 = 16384000, Y = 0; 24-bit X saturates to 8388607.
        cfg_dec = 5'd4;
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 1000, 16384, 0, 1'b0);
        idle(6);

        // Test 2: (-32768)^2 = 1073741824 per sample; 24-bit saturates to 8388607.
        cfg_dec = 5'd0;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, -32768, -32768, -32768, 1'b0);
        idle(6);

        // Test 3: gaps plus three reference drop-outs while the sample is valid.
        cyc(1'b0, 1'b0, 0, 0, 0, 1'b1);
        idle(3);
        cfg_dec = 5'd2;
        for (int i = 0; i < 40; i++) begin
            bit sv;
            bit rv;
            sv = (i % 5 != 3);
            rv = sv && !(i == 6 || i == 17 || i == 29);
            cyc(sv, rv, (i * 1237) % 30000 - 15000, i * 911 - 20000, 12000 - i * 733, 1'b0);
        end
        idle(6);
        check("mismatch32_is_3", longint'(mis32), 3);
        check("mismatch24_model", longint'(mis24), longint'(m_mis));

        // Test 4: cfg drops to 2 after 5 samples; first period still 16 long.
        cyc(1'b0, 1'b0, 0, 0, 0, 1'b1);
        idle(3);
        cfg_dec = 5'd4;
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 100 * i + 1, 300, -200, 1'b0);
        cfg_dec = 5'd2;
        for (int i = 5; i < 24; i++) cyc(1'b1, 1'b1, 100 * i + 1, 300 - i, -200 + 3 * i, 1'b0);
        idle(6);

        // Test 5: restart coincident with the 7th sample; that sample opens the new period.
        cyc(1'b0, 1'b0, 0, 0, 0, 1'b1);
        idle(3);
        cfg_dec = 5'd3;
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 5000, 7000, -3000, 1'b0);
        cyc(1'b1, 1'b1, 1234, 2000, 4000, 1'b1);
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, -20 * i - 7, 9000, 1500, 1'b0);
        idle(6);

        // Test 6: one-cycle reset after 7 of 16 samples discards the partial period.
        cyc(1'b0, 1'b0, 0, 0, 0, 1'b1);
        idle(3);
        cfg_dec = 5'd4;
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 3000, 3000, 3000, 1'b0);
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        m_cnt = 0;
        m_ax  = 0;
        m_ay  = 0;
        m_mis = 0;
        check_zero_outputs("midreset");
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 250 + i, -1000, 800, 1'b0);
        idle(6);

        for (int i = 0; i < 20 && (q32.size() != 0 || q24.size() != 0); i++) @(posedge aclk);
        check("pending32", longint'(q32.size()), 0);
        check("pending24", longint'(q24.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
